// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: shared definitions for the SPI command register block.
//   - Command byte codes carried in spi_cmd.
//   - Bit positions of the GET_STATUS readback word.
//   - Host reset pulse FSM state type.
//   - pack_status(): assembles the 64-bit status word.
package spi_cmd_pkg;

   localparam logic [7:0] CMD_RESET           = 8'h01;
   localparam logic [7:0] CMD_FORCE_TURBO     = 8'h02;
   localparam logic [7:0] CMD_GET_STATUS      = 8'h03;
   localparam logic [7:0] CMD_SET_KEYB_MATRIX = 8'h10;
   localparam logic [7:0] CMD_SET_HCTRL       = 8'h11;
   localparam logic [7:0] CMD_WRITE_KBBUF     = 8'h12;
   localparam logic [7:0] CMD_CLEAR_KBBUF     = 8'h13;
   localparam logic [7:0] CMD_SET_VIDMODE     = 8'h40;

   // Status word layout; every bit not listed reads as 0.
   localparam int ST_COUNT_MSB   = 63;
   localparam int ST_COUNT_LSB   = 56;
   localparam int ST_OVERFLOW    = 55;
   localparam int ST_TURBO       = 54;
   localparam int ST_RESET_REQ   = 53;
   localparam int ST_VIDMODE_MSB = 47;
   localparam int ST_VIDMODE_LSB = 40;

   // Payload bit carrying the cold-reset qualifier of a RESET command.
   localparam int RESET_COLD_BIT = 57;

   typedef enum logic {
      RST_IDLE  = 1'b0,
      RST_PULSE = 1'b1
   } rst_state_e;

   function automatic logic [63:0] pack_status(
      input logic [7:0] count,
      input logic       overflow,
      input logic       turbo,
      input logic       reset_req,
      input logic [7:0] video_mode
   );
      logic [63:0] s;
      s = '0;
      s[ST_COUNT_MSB:ST_COUNT_LSB]     = count;
      s[ST_OVERFLOW]                   = overflow;
      s[ST_TURBO]                      = turbo;
      s[ST_RESET_REQ]                  = reset_req;
      s[ST_VIDMODE_MSB:ST_VIDMODE_LSB] = video_mode;
      return s;
   endfunction

endpackage

// File: rtl/spi_cmd_regs_if.sv
// spi_cmd_regs_if: message-level link between the SPI slave front end and
// the command register block.
//   spi_msg_end      : one-cycle strobe, current message complete
//   spi_cmd          : command byte of the current message
//   spi_rxdata       : message payload, byte 0 in [63:56]
//   spi_txdata       : readback payload, 0 whenever not valid
//   spi_txdata_valid : readback payload valid
// Handshake: there is no backpressure. A command is consumed in exactly the
// cycle spi_msg_end is high; the register block can always accept it.
// spi_txdata_valid follows spi_cmd==GET_STATUS one cycle later and is not a
// transfer qualifier, only a "payload is meaningful" indication.
interface spi_cmd_regs_if;
   logic        spi_msg_end;
   logic [7:0]  spi_cmd;
   logic [63:0] spi_rxdata;
   logic [63:0] spi_txdata;
   logic        spi_txdata_valid;

   modport master (
      output spi_msg_end, spi_cmd, spi_rxdata,
      input  spi_txdata, spi_txdata_valid
   );

   modport slave (
      input  spi_msg_end, spi_cmd, spi_rxdata,
      output spi_txdata, spi_txdata_valid
   );
endinterface

// File: rtl/spi_cmd_regs_kbbuf_fifo.sv
// kbbuf_fifo: first-word-fall-through keyboard byte FIFO.
//   clk, reset_n : clock, asynchronous active-low reset
//   wr, wdata    : push request and data
//   rd           : pop request, ignored when empty
//   rdata        : head entry, valid whenever empty=0 (0 when empty)
//   empty, full  : occupancy flags
//   count        : occupancy, reaches exactly DEPTH when full
//   clear        : flush; overrides wr and rd in the same cycle
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module kbbuf_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     wr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     rd,
   output logic [WIDTH-1:0]         rdata,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   input  logic                     clear
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == (AW+1)'(DEPTH));
   assign count = count_q;
   // Entries are not reset, so gate the head with empty to present 00h.
   assign rdata = empty ? '0 : mem_q[rptr_q];

   always_comb begin
      do_pop  = rd & ~empty & ~clear;
      do_push = wr & ~clear & (~full | do_pop);
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (clear) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two.
         if (do_push) wptr_d = wptr_q + AW'(1);
         if (do_pop)  rptr_d = rptr_q + AW'(1);
         if (do_push && !do_pop) count_d = count_q + (AW+1)'(1);
         if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata;
   end

endmodule

// File: rtl/spi_cmd_regs.sv
// spi_cmd_regs: decodes completed SPI command messages into host-side
// control registers, a keyboard byte FIFO and a host reset pulse.
//   clk, reset_n          : clock, asynchronous active-low reset
//   spi                   : message link (command, payload, status readback)
//   reset_req(_cold)      : host reset request pulse and cold qualifier
//   keys, hctrl           : keyboard matrix, hand-controller bytes
//   kbbuf_*               : keyboard FIFO head / empty / pop / occupancy
//   force_turbo, video_mode : mode registers
//   dbg_rst_state         : reset pulse FSM state
module spi_cmd_regs
   import spi_cmd_pkg::*;
#(
   parameter int NUM_HCTRL   = 2,
   parameter int KBBUF_DEPTH = 16,
   parameter int RESET_PULSE = 16,
   parameter int VIDMODE_W   = 2
) (
   input  logic                          clk,
   input  logic                          reset_n,
   spi_cmd_regs_if.slave                 spi,
   output logic                          reset_req,
   output logic                          reset_req_cold,
   output logic [63:0]                   keys,
   output logic [8*NUM_HCTRL-1:0]        hctrl,
   output logic [7:0]                    kbbuf_rddata,
   output logic                          kbbuf_empty,
   input  logic                          kbbuf_rden,
   output logic [$clog2(KBBUF_DEPTH):0]  kbbuf_count,
   output logic                          force_turbo,
   output logic [VIDMODE_W-1:0]          video_mode,
   output rst_state_e                    dbg_rst_state
);

   logic is_reset, is_turbo, is_status, is_keys, is_hctrl;
   logic is_write, is_clear, is_vmode;

   always_comb begin
      is_reset  = spi.spi_msg_end && (spi.spi_cmd == CMD_RESET);
      is_turbo  = spi.spi_msg_end && (spi.spi_cmd == CMD_FORCE_TURBO);
      is_status = spi.spi_msg_end && (spi.spi_cmd == CMD_GET_STATUS);
      is_keys   = spi.spi_msg_end && (spi.spi_cmd == CMD_SET_KEYB_MATRIX);
      is_hctrl  = spi.spi_msg_end && (spi.spi_cmd == CMD_SET_HCTRL);
      is_write  = spi.spi_msg_end && (spi.spi_cmd == CMD_WRITE_KBBUF);
      is_clear  = spi.spi_msg_end && (spi.spi_cmd == CMD_CLEAR_KBBUF);
      is_vmode  = spi.spi_msg_end && (spi.spi_cmd == CMD_SET_VIDMODE);
   end

   // ---------------- host reset pulse ----------------
   // pulse_cnt_q holds the number of high cycles still to go, including the
   // current one, so reset_req is high for exactly RESET_PULSE cycles.
   rst_state_e  rst_state_q, rst_state_d;
   logic [15:0] pulse_cnt_q, pulse_cnt_d;
   logic        cold_q, cold_d;

   always_comb begin
      rst_state_d = rst_state_q;
      pulse_cnt_d = pulse_cnt_q;
      cold_d      = cold_q;
      if (is_reset) begin
         // A retrigger restarts the count; cold is sticky while pulsing.
         rst_state_d = RST_PULSE;
         pulse_cnt_d = 16'(RESET_PULSE);
         cold_d      = ((rst_state_q == RST_PULSE) && cold_q)
                       | spi.spi_rxdata[RESET_COLD_BIT];
      end else begin
         case (rst_state_q)
            RST_PULSE: begin
               if (pulse_cnt_q == 16'd1) begin
                  rst_state_d = RST_IDLE;
                  pulse_cnt_d = '0;
                  cold_d      = 1'b0;
               end else begin
                  pulse_cnt_d = pulse_cnt_q - 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign reset_req      = (rst_state_q == RST_PULSE);
   assign reset_req_cold = cold_q;
   assign dbg_rst_state  = rst_state_q;

   // ---------------- keyboard FIFO ----------------
   logic kb_full;

   kbbuf_fifo #(
      .DEPTH (KBBUF_DEPTH),
      .WIDTH (8)
   ) u_kbbuf (
      .clk     (clk),
      .reset_n (reset_n),
      .wr      (is_write),
      .wdata   (spi.spi_rxdata[63:56]),
      .rd      (kbbuf_rden),
      .rdata   (kbbuf_rddata),
      .empty   (kbbuf_empty),
      .full    (kb_full),
      .count   (kbbuf_count),
      .clear   (is_clear)
   );

   // ---------------- control registers ----------------
   logic [63:0]              keys_q, keys_d;
   logic [8*NUM_HCTRL-1:0]   hctrl_q, hctrl_d;
   logic                     turbo_q, turbo_d;
   logic [VIDMODE_W-1:0]     vmode_q, vmode_d;
   logic                     ovf_q, ovf_d;
   logic                     txvalid_q, txvalid_d;
   logic                     ovf_set;

   always_comb begin
      keys_d    = keys_q;
      hctrl_d   = hctrl_q;
      turbo_d   = turbo_q;
      vmode_d   = vmode_q;
      ovf_d     = ovf_q;
      txvalid_d = (spi.spi_cmd == CMD_GET_STATUS);
      // A full FIFO only drops the byte when no pop frees a slot this cycle.
      ovf_set   = is_write && kb_full && !kbbuf_rden;

      if (is_keys)  keys_d  = spi.spi_rxdata;
      // Controller 0 lands in [7:0], i.e. from the lowest selected byte.
      if (is_hctrl) hctrl_d = spi.spi_rxdata[63 -: 8*NUM_HCTRL];
      if (is_turbo) turbo_d = spi.spi_rxdata[56];
      if (is_vmode) vmode_d = spi.spi_rxdata[56 +: VIDMODE_W];

      // Overflow reported by GET_STATUS is cleared once that message ends,
      // but a drop happening in the same cycle wins.
      if (is_clear)       ovf_d = 1'b0;
      else if (ovf_set)   ovf_d = 1'b1;
      else if (is_status) ovf_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rst_state_q <= RST_IDLE;
         pulse_cnt_q <= '0;
         cold_q      <= 1'b0;
         keys_q      <= '1;
         hctrl_q     <= '1;
         turbo_q     <= 1'b0;
         vmode_q     <= '0;
         ovf_q       <= 1'b0;
         txvalid_q   <= 1'b0;
      end else begin
         rst_state_q <= rst_state_d;
         pulse_cnt_q <= pulse_cnt_d;
         cold_q      <= cold_d;
         keys_q      <= keys_d;
         hctrl_q     <= hctrl_d;
         turbo_q     <= turbo_d;
         vmode_q     <= vmode_d;
         ovf_q       <= ovf_d;
         txvalid_q   <= txvalid_d;
      end
   end

   assign keys        = keys_q;
   assign hctrl       = hctrl_q;
   assign force_turbo = turbo_q;
   assign video_mode  = vmode_q;

   // ---------------- status readback ----------------
   // The count field is 8 bits; a 256-deep full FIFO saturates to FFh.
   logic [15:0] count_wide;
   logic [7:0]  count_byte;

   always_comb begin
      count_wide = 16'(kbbuf_count);
      count_byte = (count_wide > 16'd255) ? 8'hFF : count_wide[7:0];
   end

   assign spi.spi_txdata_valid = txvalid_q;
   assign spi.spi_txdata       = txvalid_q
                                 ? pack_status(count_byte, ovf_q, turbo_q,
                                               reset_req, 8'(vmode_q))
                                 : '0;

endmodule
